// File: rtl/serial_add_sequencer_pkg.sv
// ============================================================================
//  Module   : serial_add_pkg
//  Purpose  : Shared types and constants for the serial_add_sequencer block.
//             - seq_state_t   : sequencer FSM states
//             - SA_WIDTH      : default operand/sum width
//             - seq_cnt_width : latency-counter width for a given latency
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam int SA_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // One spare bit beyond $clog2 so ADD_LATENCY-1 always fits, including
  // the ADD_LATENCY==1 case where $clog2 returns 0.
  function automatic int seq_cnt_width(input int add_latency);
    return $clog2(add_latency) + 1;
  endfunction

  localparam int SA_CNT_W = seq_cnt_width(SA_WIDTH);

endpackage

`default_nettype wire

// File: rtl/serial_add_sequencer_if.sv
// ============================================================================
//  Module   : serial_add_sequencer_if
//  Purpose  : Bundles the sequencer's operand port, result port and the pins
//             that connect to the attached serial_adder.
//  Ports    : in_valid/in_ready/in_a/in_b       operand valid/ready port
//             out_valid/out_ready/out_sum/out_cout result valid/ready port
//             out_ovf (only with SEQ_OVF_EN)     signed overflow flag
//             add_a/add_b/add_load               drive serial_adder inputs
//             add_sum/add_cout                   serial_adder results
//  Modports : slave  - the sequencer's view
//             master - the environment's view (producer/consumer/adder)
//  Config   : `define SEQ_OVF_EN to add out_ovf.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_add_sequencer_if #(
  parameter int N = 4
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
`ifdef SEQ_OVF_EN
  logic         out_ovf;
`endif
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_load;
  logic [N-1:0] add_sum;
  logic         add_cout;

`ifdef SEQ_OVF_EN
  modport slave (
    input  in_valid, in_a, in_b, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, out_ovf,
           add_a, add_b, add_load
  );
  modport master (
    output in_valid, in_a, in_b, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf,
           add_a, add_b, add_load
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout,
           add_a, add_b, add_load
  );
  modport master (
    output in_valid, in_a, in_b, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout,
           add_a, add_b, add_load
  );
`endif

endinterface

`default_nettype wire

// File: rtl/serial_add_sequencer_latency_counter.sv
// ============================================================================
//  Module   : seq_latency_counter
//  Purpose  : Clearable up-counter with a terminal-count flag that is high
//             while the count equals ADD_LATENCY-1.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous active-high reset (count -> 0)
//             i_clr  - synchronous clear (count -> 0)
//             i_en   - count enable
//             o_tc   - terminal count reached
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_latency_counter #(
  parameter int ADD_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  i_clr,
  input  wire  i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] c_TC_VALUE = CNT_W'(ADD_LATENCY - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == c_TC_VALUE);

endmodule

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
// ============================================================================
//  Module   : serial_add_sequencer
//  Purpose  : Transaction front-end for an N-bit serial_adder. Accepts one
//             operand pair, pulses the adder's load pin, waits ADD_LATENCY
//             cycles, captures sum/cout and offers them on the result port.
//             One transaction in flight at a time.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous active-high reset (shared with the adder)
//             bus    - serial_add_sequencer_if.slave (operand port, result
//                      port and serial_adder pins)
//  Params   : N           - operand/sum width (must match the adder)
//             ADD_LATENCY - cycles from the adder's load edge to a stable
//                           sum/cout; must be >= 1
//  Config   : `define SEQ_OVF_EN adds bus.out_ovf, the signed two's-complement
//             overflow flag captured alongside out_sum.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int N           = SA_WIDTH,
  parameter int ADD_LATENCY = N
) (
  input wire                    clk,
  input wire                    reset,
  serial_add_sequencer_if.slave bus
);

  localparam int c_CNT_W = seq_cnt_width(ADD_LATENCY);

  seq_state_t   r_state;
  seq_state_t   w_state_nxt;

  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_add_load;
  logic         w_accept;
  logic         w_capture;
  logic         w_cnt_clr;
  logic         w_cnt_en;
  logic         w_tc;

  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_sum;
  logic         r_cout;

  // --------------------------------------------------------------------------
  // Latency counter: cleared in LOAD so that the first RUN cycle sees 0 and
  // the terminal count lands on the ADD_LATENCY-th edge after the load edge.
  // --------------------------------------------------------------------------
  seq_latency_counter #(
    .ADD_LATENCY (ADD_LATENCY),
    .CNT_W       (c_CNT_W)
  ) u_latency_counter (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and decoded outputs. Handshake outputs are pure state
  // decodes, so reset values follow directly from r_state == IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_add_load  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_add_load  = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_cnt_en = 1'b1;
        if (w_tc) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand and result registers. Operands are only written on acceptance,
  // so the adder inputs stay stable from LOAD through DONE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= bus.in_a;
        r_b <= bus.in_b;
      end
      if (w_capture) begin
        r_sum  <= bus.add_sum;
        r_cout <= bus.add_cout;
      end
    end
  end

`ifdef SEQ_OVF_EN
  // Signed overflow: operands share a sign and the sum's sign differs.
  logic r_ovf;
  logic w_ovf;

  assign w_ovf = (r_a[N-1] == r_b[N-1]) && (bus.add_sum[N-1] != r_a[N-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_capture) begin
      r_ovf <= w_ovf;
    end
  end

  assign bus.out_ovf = r_ovf;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.add_a     = r_a;
  assign bus.add_b     = r_b;
  assign bus.add_load  = w_add_load;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
// ============================================================================
//  Module   : tb_serial_add_sequencer
//  Purpose  : Self-checking bench for serial_add_sequencer. A behavioural
//             stand-in for serial_adder produces a wrong value until
//             ADD_LATENCY edges after its load edge, then the true sum.
//             Expected results come from plain integer arithmetic.
//  Config   : `define SEQ_OVF_EN to also exercise out_ovf.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sequencer;

  localparam int N = 4;
  localparam int L = N;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int cyc      = 0;
  int n_load   = 0;
  int n_checks = 0;
  int n_errors = 0;

  serial_add_sequencer_if #(.N(N)) bus ();

  serial_add_sequencer #(
    .N           (N),
    .ADD_LATENCY (L)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.add_load === 1'b1) n_load <= n_load + 1;
  end

  // Adder stand-in: result is only correct once enough edges have passed
  // since the load edge; before that it shows the bitwise complement.
  logic [N-1:0] m_a, m_b;
  logic         m_busy;
  int           m_k;
  logic [N:0]   m_true;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_a    <= '0;
      m_b    <= '0;
    end else if (bus.add_load === 1'b1) begin
      m_a    <= bus.add_a;
      m_b    <= bus.add_b;
      m_k    <= 0;
      m_busy <= 1'b1;
    end else if (m_busy && m_k < 1000) begin
      m_k <= m_k + 1;
    end
  end

  assign m_true = {1'b0, m_a} + {1'b0, m_b};
  assign {bus.add_cout, bus.add_sum} = (m_busy && m_k >= L - 1) ? m_true : ~m_true;

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b);
    int s;
    s = (int'(a) + int'(b)) % (1 << N);
    return N'(s);
  endfunction

  function automatic logic ref_cout(input logic [N-1:0] a, input logic [N-1:0] b);
    return (int'(a) + int'(b)) >= (1 << N);
  endfunction

`ifdef SEQ_OVF_EN
  function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb, s;
    sa = (int'(a) >= (1 << (N - 1))) ? int'(a) - (1 << N) : int'(a);
    sb = (int'(b) >= (1 << (N - 1))) ? int'(b) - (1 << N) : int'(b);
    s  = sa + sb;
    return (s > (1 << (N - 1)) - 1) || (s < -(1 << (N - 1)));
  endfunction
`endif

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and wait (bounded) for its acceptance edge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic hold,
                      output int acc, output int load0);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    acc          = -1;
    load0        = n_load;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready === 1'b1) begin
        load0 = n_load;
        tick();
        acc = cyc;
        break;
      end
      tick();
    end
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and check result, latency and load pulse.
  task automatic wait_valid(input logic [N-1:0] a, input logic [N-1:0] b,
                            input int acc, input int load0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      check("busy_add_a", 32'(bus.add_a), 32'(a));
      check("busy_add_b", 32'(bus.add_b), 32'(b));
      tick();
    end
    if (!ok) begin
      check("valid_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(cyc - acc), 32'(L + 1));
      check("sum", 32'(bus.out_sum), 32'(ref_sum(a, b)));
      check("cout", 32'(bus.out_cout), 32'(ref_cout(a, b)));
      check("load_pulses", 32'(n_load - load0), 32'd1);
      check("done_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef SEQ_OVF_EN
      check("ovf", 32'(bus.out_ovf), 32'(ref_ovf(a, b)));
`endif
    end
  endtask

  task automatic stall(input int n, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_sum", 32'(bus.out_sum), 32'(ref_sum(a, b)));
      check("stall_cout", 32'(bus.out_cout), 32'(ref_cout(a, b)));
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
  endtask

  task automatic finish_txn();
    bus.out_ready = 1'b1;
    tick();
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int acc, load0, acc_prev, hs;
    logic [N-1:0] pa [3];
    logic [N-1:0] pb [3];

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_add_load", 32'(bus.add_load), 32'd0);
    check("rst_add_a", 32'(bus.add_a), 32'd0);
    check("rst_add_b", 32'(bus.add_b), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_cout", 32'(bus.out_cout), 32'd0);
    reset = 1'b0;
    tick();

    // Basic add with carry
    bus.out_ready = 1'b1;
    send(4'b1010, 4'b0111, 1'b0, acc, load0);
    wait_valid(4'b1010, 4'b0111, acc, load0);
    check("basic_sum_const", 32'(bus.out_sum), 32'b0001);
    check("basic_cout_const", 32'(bus.out_cout), 32'd1);
    finish_txn();

    // No carry
    send(4'b0011, 4'b0100, 1'b0, acc, load0);
    wait_valid(4'b0011, 4'b0100, acc, load0);
    check("nocarry_sum_const", 32'(bus.out_sum), 32'b0111);
    check("nocarry_cout_const", 32'(bus.out_cout), 32'd0);
    finish_txn();

    // Backpressure with a second pair offered during the stall
    bus.out_ready = 1'b0;
    send(4'b1111, 4'b1111, 1'b0, acc, load0);
    wait_valid(4'b1111, 4'b1111, acc, load0);
    check("bp_sum_const", 32'(bus.out_sum), 32'b1110);
    bus.in_valid = 1'b1;
    bus.in_a     = 4'b0010;
    bus.in_b     = 4'b0011;
    stall(10, 4'b1111, 4'b1111);
    check("bp_add_a_held", 32'(bus.add_a), 32'b1111);
    finish_txn();
    hs = cyc;
    send(4'b0010, 4'b0011, 1'b0, acc, load0);
    check("bp_accept_next", 32'(acc - hs), 32'd1);
    wait_valid(4'b0010, 4'b0011, acc, load0);
    finish_txn();

    // Reset in the middle of RUN
    send(4'b0101, 4'b0110, 1'b0, acc, load0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_add_load", 32'(bus.add_load), 32'd0);
    check("midrst_add_a", 32'(bus.add_a), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst_no_result", 32'(bus.out_valid), 32'd0);
    end

    // Back-to-back with in_valid held continuously
    pa[0] = 4'b0001; pb[0] = 4'b0001;
    pa[1] = 4'b0010; pb[1] = 4'b0010;
    pa[2] = 4'b1000; pb[2] = 4'b1000;
    bus.out_ready = 1'b1;
    acc_prev = 0;
    for (int i = 0; i < 3; i++) begin
      send(pa[i], pb[i], (i < 2), acc, load0);
      if (i > 0) check("b2b_spacing", 32'(acc - acc_prev), 32'(L + 3));
      acc_prev = acc;
      if (i < 2) begin
        bus.in_a = pa[i+1];
        bus.in_b = pb[i+1];
      end
      wait_valid(pa[i], pb[i], acc, load0);
      finish_txn();
    end
    check("b2b_last_sum", 32'(bus.out_sum), 32'b0000);
    check("b2b_last_cout", 32'(bus.out_cout), 32'd1);

`ifdef SEQ_OVF_EN
    send(4'b0111, 4'b0001, 1'b0, acc, load0);
    wait_valid(4'b0111, 4'b0001, acc, load0);
    check("ovf1_const", 32'(bus.out_ovf), 32'd1);
    finish_txn();
    send(4'b1000, 4'b1000, 1'b0, acc, load0);
    wait_valid(4'b1000, 4'b1000, acc, load0);
    check("ovf2_const", 32'(bus.out_ovf), 32'd1);
    finish_txn();
    send(4'b0011, 4'b0100, 1'b0, acc, load0);
    wait_valid(4'b0011, 4'b0100, acc, load0);
    check("ovf3_const", 32'(bus.out_ovf), 32'd0);
    finish_txn();
`endif

    // Randomized pairs with random result backpressure
    for (int t = 0; t < 20; t++) begin
      logic [N-1:0] ra, rb;
      int st;
      ra = N'($urandom);
      rb = N'($urandom);
      st = int'($urandom_range(0, 3));
      bus.out_ready = (st == 0);
      send(ra, rb, 1'b0, acc, load0);
      wait_valid(ra, rb, acc, load0);
      if (st > 0) stall(st, ra, rb);
      finish_txn();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
